// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin merge of two writeback requesters onto one
// register-file write port, with a pending-write scoreboard and stall counter.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    output logic [31:0] busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        GR_A = 1'b0,
        GR_B = 1'b1
    } grant_e;

    grant_e      last_q, last_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] busy_q, busy_d;
    logic [15:0] cnt_q, cnt_d;

    logic        pick_a, pick_b;
    logic        hs_a, hs_b, hs;
    logic [4:0]  hs_addr;
    logic [31:0] hs_data;
    logic        contend;

    // On a tie the requester that did not win the last handshake goes next.
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                pick_a = (last_q == GR_B);
                pick_b = (last_q == GR_A);
            end else begin
                pick_a = a_valid;
                pick_b = b_valid;
            end
        end
    end

    assign a_ready = pick_a;
    assign b_ready = pick_b;

    assign hs_a    = a_valid & pick_a;
    assign hs_b    = b_valid & pick_b;
    assign hs      = hs_a | hs_b;
    assign hs_addr = hs_a ? a_addr : b_addr;
    assign hs_data = hs_a ? a_data : b_data;
    assign contend = a_valid & b_valid & ~rst;

    always_comb begin
        last_d  = last_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;

        if (hs_a) begin
            last_d = GR_A;
        end else if (hs_b) begin
            last_d = GR_B;
        end

        if (hs) begin
            we_d    = (hs_addr != 5'd0);
            waddr_d = hs_addr;
            wdata_d = hs_data;
        end

        // Clear first so a same-cycle issue to that register keeps it busy.
        if (hs && hs_addr != 5'd0) begin
            busy_d[hs_addr] = 1'b0;
        end
        if (issue_valid && issue_addr != 5'd0) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (contend && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= GR_B;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            busy_q  <= 32'd0;
            cnt_q   <= 16'd0;
        end else begin
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset also masks outputs in the cycle it is raised, killing a write
    // registered from the previous cycle's handshake.
    assign rf_we     = we_q & ~rst;
    assign rf_waddr  = rst ? 5'd0  : waddr_q;
    assign rf_wdata  = rst ? 32'd0 : wdata_q;
    assign busy      = rst ? 32'd0 : busy_q;
    assign stall_cnt = rst ? 16'd0 : cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: cycle model plus directed cases.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_addr, b_addr, issue_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [15:0] stall_cnt;

    int nvec = 0;
    int nmis = 0;
    bit run  = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .busy(busy), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .stall_cnt(stall_cnt)
    );

    // Model: 0 = A, 1 = B, -1 = nobody
    int          m_last;
    int          m_cnt;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          g;
    logic [4:0]  ad;
    logic [31:0] dt;

    function automatic int winner(input logic av, input logic bv,
                                  input int last);
        if (av && bv) return (last == 1) ? 0 : 1;
        if (av) return 0;
        if (bv) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_last = 1; m_cnt = 0; m_busy = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0;
        end else begin
            g = winner(a_valid, b_valid, m_last);
            if (a_valid && b_valid && m_cnt < 65535) m_cnt++;
            m_we = 0;
            if (g >= 0) begin
                ad = (g == 0) ? a_addr : b_addr;
                dt = (g == 0) ? a_data : b_data;
                m_we = (ad != 0);
                m_waddr = ad;
                m_wdata = dt;
                m_last = g;
                if (ad != 0) m_busy[ad] = 1'b0;
            end
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            int w;
            w = rst ? -1 : winner(a_valid, b_valid, m_last);
            chk("a_ready", {31'd0, a_ready}, {31'd0, w == 0});
            chk("b_ready", {31'd0, b_ready}, {31'd0, w == 1});
            chk("rf_we", {31'd0, rf_we}, {31'd0, m_we & ~rst});
            chk("rf_waddr", {27'd0, rf_waddr}, rst ? 0 : {27'd0, m_waddr});
            chk("rf_wdata", rf_wdata, rst ? 0 : m_wdata);
            chk("busy", busy, rst ? 0 : m_busy);
            chk("stall_cnt", {16'd0, stall_cnt}, rst ? 0 : m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; issue_valid = 0;
    endtask

    initial begin
        rst = 1; idle();
        a_addr = 0; a_data = 0; b_addr = 0; b_data = 0; issue_addr = 0;
        tick(); run = 1; tick();
        @(negedge clk);
        chk("rst_we", {31'd0, rf_we}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", {16'd0, stall_cnt}, 0);
        rst = 0;
        tick();

        // single A request
        a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
        @(negedge clk); chk("single_rdy", {31'd0, a_ready}, 1);
        tick(); a_valid = 0;
        @(negedge clk);
        chk("single_we", {31'd0, rf_we}, 1);
        chk("single_wa", {27'd0, rf_waddr}, 5);
        chk("single_wd", rf_wdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("single_we_off", {31'd0, rf_we}, 0);
        chk("single_hold", rf_wdata, 32'hDEADBEEF);

        // tie right after reset: A first, then B
        rst = 1; tick(); rst = 0;
        a_valid = 1; a_addr = 3; a_data = 1;
        b_valid = 1; b_addr = 4; b_data = 2;
        @(negedge clk);
        chk("tie_a", {30'd0, a_ready, b_ready}, 2);
        tick(); a_valid = 0;
        @(negedge clk);
        chk("tie_b", {30'd0, a_ready, b_ready}, 1);
        chk("tie_w1", {27'd0, rf_waddr}, 3);
        chk("tie_d1", rf_wdata, 1);
        tick(); b_valid = 0;
        @(negedge clk);
        chk("tie_w2", {27'd0, rf_waddr}, 4);
        chk("tie_d2", rf_wdata, 2);
        chk("tie_cnt", {16'd0, stall_cnt}, 1);
        tick();

        // scoreboard set / same-cycle set+clear / clear
        issue_valid = 1; issue_addr = 7;
        tick(); issue_valid = 0;
        @(negedge clk); chk("sb_set", busy, 32'h80);
        a_valid = 1; a_addr = 7; a_data = 77;
        issue_valid = 1; issue_addr = 7;
        tick(); issue_valid = 0;
        @(negedge clk); chk("sb_keep", busy, 32'h80);
        a_data = 78;
        tick(); a_valid = 0;
        @(negedge clk);
        chk("sb_clr", busy, 0);
        chk("sb_wd", rf_wdata, 78);

        // x0 writeback is accepted but not written
        issue_valid = 1; issue_addr = 9;
        tick(); issue_valid = 0;
        b_valid = 1; b_addr = 0; b_data = 32'h1234;
        @(negedge clk); chk("x0_rdy", {31'd0, b_ready}, 1);
        tick(); b_valid = 0;
        @(negedge clk);
        chk("x0_we", {31'd0, rf_we}, 0);
        chk("x0_busy", busy, 32'h200);
        issue_valid = 1; issue_addr = 0;
        tick(); issue_valid = 0;
        @(negedge clk); chk("x0_issue", busy, 32'h200);

        // mid-operation reset kills the pending write
        a_valid = 1; a_addr = 9; a_data = 55;
        issue_valid = 1; issue_addr = 11;
        tick();
        rst = 1; b_valid = 1; b_addr = 6; b_data = 66;
        issue_valid = 1; issue_addr = 12;
        @(negedge clk);
        chk("mr_we", {31'd0, rf_we}, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rdy", {30'd0, a_ready, b_ready}, 0);
        tick();
        rst = 0; idle();
        @(negedge clk);
        chk("mr_nowr", {31'd0, rf_we}, 0);
        chk("mr_noiss", busy, 0);
        chk("mr_cnt", {16'd0, stall_cnt}, 0);

        // saturation under continuous contention
        a_valid = 1; a_addr = 1; a_data = 32'hA;
        b_valid = 1; b_addr = 2; b_data = 32'hB;
        for (int i = 0; i < 65540; i++) tick();
        @(negedge clk);
        chk("sat", {16'd0, stall_cnt}, 32'hFFFF);
        tick(); idle();
        tick();
        @(negedge clk);
        chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
